// File: rtl/lr_pkg.sv
// Shared definitions for the linear-regression datapath.
// DATA_W/FRAC_W describe the Q8.8 fixed-point word used on every lane.
// MAX_FEATURES is the number of feature lanes, with one multiplier per lane.
package lr_pkg;
  localparam int DATA_W       = 16;
  localparam int FRAC_W       = 8;
  localparam int MAX_FEATURES = 7;

  // Signed Q8.8 two's-complement word.
  typedef logic signed [DATA_W-1:0] fixed_t;
endpackage

// File: rtl/baugh_wooley_mul_if.sv
// Operand/result bundle for one multiplier lane. There is no handshake:
// the lane accepts a new operand pair on every cycle.
//   a, b : signed Q8.8 operands (master -> slave)
//   p    : registered Q8.8 product (slave -> master)
interface baugh_wooley_mul_if;
  import lr_pkg::*;
  fixed_t a;
  fixed_t b;
  fixed_t p;

  modport master (output a, output b, input p);
  modport slave  (input a, input b, output p);
endinterface

// File: rtl/bw_cell.sv
// One Baugh-Wooley array cell. It forms a partial-product bit, using AND,
// or NAND when inv is set for the cross-sign terms. It then adds that bit
// to the incoming sum and carry with a full adder.
//   a_bit, b_bit : operand bits forming the partial product
//   inv          : invert the partial product
//   sum_in       : sum arriving from the previous row
//   carry_in     : carry arriving from the previous row
//   sum_out      : sum leaving this cell
//   carry_out    : carry leaving this cell
module bw_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic inv,
  input  logic sum_in,
  input  logic carry_in,
  output logic sum_out,
  output logic carry_out
);
  logic pp;

  assign pp        = (a_bit & b_bit) ^ inv;
  assign sum_out   = pp ^ sum_in ^ carry_in;
  assign carry_out = (pp & sum_in) | (pp & carry_in) | (sum_in & carry_in);
endmodule

// File: rtl/baugh_wooley_mul.sv
// Signed WIDTHxWIDTH Baugh-Wooley multiplier with a registered Q-format
// result. The full 2*WIDTH product is summed by a carry-save cell array and
// a final ripple adder. The result is the slice prod[FRAC_BITS+WIDTH-1:FRAC_BITS].
// Taking that slice is the same as an arithmetic shift right, so the result
// rounds toward minus infinity, and overflow wraps.
//   CLK    : rising-edge clock
//   RST    : synchronous active-high reset; clears p
//   mul_if : a, b operands in, p product out (1 cycle latency)
module baugh_wooley_mul
  import lr_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter int FRAC_BITS = FRAC_W
) (
  input  logic               CLK,
  input  logic               RST,
  baugh_wooley_mul_if.slave  mul_if
);
  localparam int W = WIDTH;

  logic [W-1:0]   a_v, b_v;
  logic [2*W-1:0] prod;
  logic [W-1:0]   p_d, p_q;
  logic           unused_bits;

  assign a_v = mul_if.a;
  assign b_v = mul_if.b;

  // Row i adds partial products a[j]&b[i] at weight i+j. Cell (i,j) takes the
  // previous row's sum at weight i+j, which is s[j+1], and its carry, c[j].
  // The top cell of each row has no sum input from the row above. In row 1,
  // that slot sits at weight W and carries the constant 2^W.
  for (genvar i = 0; i < W; i++) begin : g_row
    logic [W-1:0] s, c;
    for (genvar j = 0; j < W; j++) begin : g_col
      localparam bit INV = (i == W-1) != (j == W-1);
      logic s_in, c_in;
      if (i == 0) begin : g_first
        assign s_in = 1'b0;
        assign c_in = 1'b0;
      end else begin : g_next
        if (j < W-1) begin : g_sin
          assign s_in = g_row[i-1].s[j+1];
        end else begin : g_stop
          assign s_in = (i == 1) ? 1'b1 : 1'b0;
        end
        assign c_in = g_row[i-1].c[j];
      end
      bw_cell u_cell (
        .a_bit     (a_v[j]),
        .b_bit     (b_v[i]),
        .inv       (INV),
        .sum_in    (s_in),
        .carry_in  (c_in),
        .sum_out   (s[j]),
        .carry_out (c[j])
      );
    end
    assign prod[i] = s[0];
  end

  // Final ripple adder over the upper half. The sum vector of the last row
  // ends at weight 2W-2, so its missing MSB slot carries the constant 2^(2W-1).
  for (genvar m = 0; m < W; m++) begin : g_rca
    logic x, y, ci, co;
    if (m < W-1) begin : g_x
      assign x = g_row[W-1].s[m+1];
    end else begin : g_xk
      assign x = 1'b1;
    end
    assign y = g_row[W-1].c[m];
    if (m == 0) begin : g_c0
      assign ci = 1'b0;
    end else begin : g_cn
      assign ci = g_rca[m-1].co;
    end
    assign prod[W+m] = x ^ y ^ ci;
    assign co        = (x & y) | (x & ci) | (y & ci);
  end

  assign p_d = prod[FRAC_BITS+W-1:FRAC_BITS];

  // Dropped fraction bits, wrapped high bits and the final carry-out.
  assign unused_bits = ^{prod[FRAC_BITS-1:0], prod[2*W-1:FRAC_BITS+W], g_rca[W-1].co};

  always_ff @(posedge CLK) begin
    if (RST) p_q <= '0;
    else     p_q <= p_d;
  end

  assign mul_if.p = p_q;
endmodule

// File: tb/tb_baugh_wooley_mul.sv
// Self-checking bench for baugh_wooley_mul. Inputs are driven on the falling
// edge, and p is sampled 1 ns after the rising edge that loads it.
module tb_baugh_wooley_mul;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  baugh_wooley_mul_if mul_if ();

  baugh_wooley_mul dut (
    .CLK    (CLK),
    .RST    (RST),
    .mul_if (mul_if)
  );

  always #5 CLK = ~CLK;

  // Reference: full signed product, then floor(prod / 256), keeping 16 bits.
  function automatic logic [15:0] golden(input logic [15:0] a, input logic [15:0] b);
    longint pa, pb, pr;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    pr = pa * pb;
    pr = pr >>> 8;
    return pr[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one operand pair and reset level, then sample p after the edge.
  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    RST      = r;
    mul_if.a = a;
    mul_if.b = b;
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] ra, rb;

  initial begin
    mul_if.a = 16'h1234;
    mul_if.b = 16'h5678;
    step(1'b1, 16'h7abc, 16'h4321);
    chk("reset", mul_if.p, 16'h0000);

    step(1'b0, 16'h0100, 16'h0040); chk("scale1", mul_if.p, 16'h0040);
    step(1'b0, 16'h0600, 16'h0040); chk("scale2", mul_if.p, 16'h0180);
    step(1'b0, 16'hFF00, 16'h0200); chk("neg_pos", mul_if.p, 16'hFE00);
    step(1'b0, 16'hFF00, 16'hFF00); chk("neg_neg", mul_if.p, 16'h0100);
    step(1'b0, 16'h0001, 16'hFFFF); chk("floor_neg", mul_if.p, 16'hFFFF);
    step(1'b0, 16'h0001, 16'h0001); chk("floor_pos", mul_if.p, 16'h0000);
    step(1'b0, 16'h7FFF, 16'h7FFF); chk("wrap_max", mul_if.p, 16'hFF00);
    step(1'b0, 16'h8000, 16'h8000); chk("wrap_min", mul_if.p, 16'h0000);
    step(1'b0, 16'h8000, 16'h7FFF); chk("wrap_mix", mul_if.p, 16'h0080);
    step(1'b0, 16'h0000, 16'h0000); chk("zeros", mul_if.p, 16'h0000);
    step(1'b0, 16'hFFFF, 16'hFFFF); chk("ones", mul_if.p, 16'h0000);
    step(1'b0, 16'hFFFF, 16'h8000); chk("ones_min", mul_if.p, 16'h0080);

    // Mid-stream reset with operands held.
    step(1'b0, 16'h0300, 16'h0200); chk("stream", mul_if.p, 16'h0600);
    step(1'b0, 16'h0300, 16'h0200); chk("held", mul_if.p, 16'h0600);
    step(1'b1, 16'h0300, 16'h0200); chk("mid_rst", mul_if.p, 16'h0000);
    step(1'b0, 16'h0300, 16'h0200); chk("post_rst", mul_if.p, 16'h0600);

    // Back-to-back random pairs.
    for (int k = 0; k < 10000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (k % 500)
        0: ra = 16'h0000;
        1: rb = 16'hFFFF;
        2: begin ra = 16'hFFFF; rb = 16'hFFFF; end
        3: begin ra = 16'h8000; rb = 16'($urandom); end
        default: ;
      endcase
      step(1'b0, ra, rb);
      chk("random", mul_if.p, golden(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
